distance_averager: RTL and testbench
====================================

// Module: distance_averager
// PURPOSE
// - Boxcar moving-average filter on raw sensor distance samples; output drives the `distance` input of the AM sine stage.
// - Smooths jitter so AM envelope does not flicker. Upstream: sensor/capture logic with valid/ready; downstream samples out_distance each enabled cycle.
// - Average = sum of last DEPTH accepted samples >> LOG2_DEPTH; buffer zero-initialised so output ramps up after reset/flush.
// PARAMETERS
// - WIDTH        13  bit width of in_distance/out_distance (matches AM stage distance width)
// - LOG2_DEPTH   4   log2 of window length; DEPTH = 2**LOG2_DEPTH samples (16)
// - SUM_WIDTH    WIDTH+LOG2_DEPTH  running-sum width; no overflow possible
// PORTS
// - clk           in   1          system clock
// - reset         in   1          synchronous, active-high reset
// - enable        in   1          global clock enable; low freezes all state, forces in_ready low
// - flush         in   1          sync request: clear window, restart averaging
// - in_valid      in   1          in_distance holds a sample
// - in_distance   in   WIDTH      raw distance sample, unsigned
// - in_ready      out  1          filter can accept sample this cycle
// - out_distance  out  WIDTH      registered average, unsigned; held between updates
// - out_valid     out  1          1-cycle pulse: out_distance just updated
// - filled        out  1          high once DEPTH samples accepted since last clear
// BEHAVIOUR
// - States: CLEAR, RUN. reset -> CLEAR. flush (with enable) in any state -> CLEAR, clear counter restarts at 0.
// - CLEAR: writes 0 to buf[clr_cnt] per enabled cycle, clr_cnt 0..DEPTH-1; after writing DEPTH-1 -> RUN. Takes exactly DEPTH enabled cycles.
//   sum, wr_ptr, fill_cnt, out_distance forced to 0 on entry; filled=0; in_ready=0 throughout.
// - in_ready = enable && state==RUN && !flush (combinational). Flush beats a simultaneous sample: no handshake, sample not consumed.
// - Accept at edge t when in_valid && in_ready: old = buf[wr_ptr] (comb read);
//   sum <= sum + in_distance - old; buf[wr_ptr] <= in_distance; wr_ptr <= wr_ptr+1 mod DEPTH (natural wrap).
// - Latency 1: at t+1 out_distance = (sum+new-old)>>LOG2_DEPTH, truncated (floor). out_valid high for that cycle only.
// - No accept -> out_distance holds, out_valid=0. Back-to-back accepts every cycle supported, one result per accept.
// - fill_cnt saturates at DEPTH; filled = (fill_cnt==DEPTH), registered with the accept that reaches DEPTH.
// - Arithmetic unsigned; subtraction never underflows because sum includes old. Sum width SUM_WIDTH exact.
// - Reset values: out_distance=0, out_valid=0, filled=0, in_ready=0 (state CLEAR), sum=0, wr_ptr=0.
// - Reset/flush mid-RUN discards window; no out_valid issued for the discarded state.
// - enable low mid-CLEAR pauses clr_cnt; mid-RUN holds all regs; out_valid pulse never stretched (cleared when enable low).
// STRUCTURE
// - Package distance_pkg: WIDTH default, LOG2_MAX_DIST, typedef distance_t = logic [WIDTH-1:0], enum avg_state_e {CLEAR, RUN}.
// - Sub-module sample_ring_buffer: DEPTH x WIDTH register array, one sync write port, one async read port; no reset on storage (CLEAR zeros it).
// - Top holds FSM, clr_cnt, wr_ptr, fill_cnt, sum, output regs.
// TESTING (LOG2_DEPTH=2, DEPTH=4 unless noted)
// - Reset then enable=1, in_valid=1: in_ready low for exactly 4 cycles, then high; out_distance=0, filled=0 throughout.
// - Accept 100,200,300,400 back-to-back -> out_distance 25,75,150,250 on following cycles, 4 out_valid pulses; filled rises with 4th result.
// - Continue with 800 -> out_distance=(200+300+400+800)/4=425; wr_ptr wrapped 3->0; 8191x4 -> 8191 (no overflow).
// - Accept 1,1,1,2 -> outputs 0,0,0,1 (floor truncation).
// - flush asserted same cycle as in_valid after 3 samples: in_ready=0, sample not taken; 4 CLEAR cycles; next sample 40 -> out 10, filled=0.
// - enable toggled low 2 cycles mid-CLEAR and mid-RUN: CLEAR lasts 4 enabled cycles; outputs/sum frozen; out_valid one cycle wide.

Source files
------------

// File: rtl/distance_pkg.sv
// Shared types and defaults for the distance smoothing path.
package distance_pkg;

  // Distance width used by the AM sine stage and its feeders.
  localparam int unsigned DEFAULT_WIDTH = 13;

  // log2 of the largest representable distance plus one.
  localparam int unsigned LOG2_MAX_DIST = DEFAULT_WIDTH;

  typedef logic [DEFAULT_WIDTH-1:0] distance_t;

  // CLEAR zeroes the window slot by slot; RUN accepts samples.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } avg_state_e;

endpackage : distance_pkg

// File: rtl/distance_averager_ring_buffer.sv
// Sample window storage: DEPTH x WIDTH registers, one synchronous write port
// and one asynchronous read port. Storage has no reset; the owner zeroes it.
module sample_ring_buffer #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single write port; the slot being overwritten is read combinationally.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : sample_ring_buffer

// File: rtl/distance_averager.sv
// Boxcar moving average over the last DEPTH accepted distance samples.
// Keeps a running sum: each accept adds the new sample and subtracts the one
// it overwrites, so the average is one shift of the sum.
module distance_averager
  import distance_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned LOG2_DEPTH = 4,
  parameter int unsigned SUM_WIDTH  = WIDTH + LOG2_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_distance,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_distance,
  output logic             out_valid,
  output logic             filled
);

  localparam int unsigned             DEPTH     = 2**LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0]   LAST_SLOT = '1;
  localparam logic [LOG2_DEPTH:0]     FULL_CNT  = (LOG2_DEPTH+1)'(DEPTH);

  avg_state_e            state_q, state_d;
  logic [LOG2_DEPTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]   fill_cnt_q, fill_cnt_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]      out_distance_q, out_distance_d;
  logic                  out_valid_q, out_valid_d;
  logic                  filled_q, filled_d;

  logic                  buf_we;
  logic [LOG2_DEPTH-1:0] buf_waddr;
  logic [WIDTH-1:0]      buf_wdata;
  logic [WIDTH-1:0]      old_sample;
  logic [SUM_WIDTH-1:0]  sum_next;
  logic                  accept;

  sample_ring_buffer #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (LOG2_DEPTH),
    .DEPTH      (DEPTH)
  ) u_ring (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (wr_ptr_q),
    .rdata (old_sample)
  );

  // Flush wins over a simultaneous sample, so ready drops combinationally.
  assign in_ready = enable && (state_q == RUN) && !flush;
  assign accept   = in_valid && in_ready;

  // The sum already contains old_sample, so the subtraction cannot underflow.
  assign sum_next = sum_q + SUM_WIDTH'(in_distance) - SUM_WIDTH'(old_sample);

  // Next-state, window write control and output update.
  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    wr_ptr_d       = wr_ptr_q;
    fill_cnt_d     = fill_cnt_q;
    sum_d          = sum_q;
    out_distance_d = out_distance_q;
    out_valid_d    = 1'b0;
    filled_d       = filled_q;
    buf_we         = 1'b0;
    buf_waddr      = wr_ptr_q;
    buf_wdata      = in_distance;

    if (enable) begin
      if (flush) begin
        state_d        = CLEAR;
        clr_cnt_d      = '0;
        wr_ptr_d       = '0;
        fill_cnt_d     = '0;
        sum_d          = '0;
        out_distance_d = '0;
        filled_d       = 1'b0;
      end else begin
        unique case (state_q)
          CLEAR: begin
            buf_we    = 1'b1;
            buf_waddr = clr_cnt_q;
            buf_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_SLOT) begin
              state_d = RUN;
            end
          end
          RUN: begin
            if (accept) begin
              buf_we         = 1'b1;
              sum_d          = sum_next;
              wr_ptr_d       = wr_ptr_q + 1'b1;
              out_distance_d = WIDTH'(sum_next >> LOG2_DEPTH);
              out_valid_d    = 1'b1;
              if (fill_cnt_q != FULL_CNT) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
              end
              filled_d = (fill_cnt_d == FULL_CNT);
            end
          end
          default: state_d = CLEAR;
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CLEAR;
      clr_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      fill_cnt_q     <= '0;
      sum_q          <= '0;
      out_distance_q <= '0;
      out_valid_q    <= 1'b0;
      filled_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_cnt_q     <= fill_cnt_d;
      sum_q          <= sum_d;
      out_distance_q <= out_distance_d;
      out_valid_q    <= out_valid_d;
      filled_q       <= filled_d;
    end
  end

  assign out_distance = out_distance_q;
  assign out_valid    = out_valid_q;
  assign filled       = filled_q;

endmodule : distance_averager

// File: tb/tb_distance_averager.sv
// Bench for distance_averager with a 4-sample window.
module tb_distance_averager;

  localparam int W  = 13;
  localparam int L2 = 2;
  localparam int D  = 4;

  typedef struct {
    bit en;
    bit fl;
    bit v;
    int d;
  } stim_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_distance;
  logic         in_ready;
  logic [W-1:0] out_distance;
  logic         out_valid;
  logic         filled;

  always #5 clk = ~clk;

  distance_averager #(
    .WIDTH      (W),
    .LOG2_DEPTH (L2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_distance  (in_distance),
    .in_ready     (in_ready),
    .out_distance (out_distance),
    .out_valid    (out_valid),
    .filled       (filled)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  // Reference window model.
  int   win[D];
  int   mptr;
  int   msum;
  int   mfill;
  int   clr_left;
  int   last_out;
  logic rdy_obs;
  logic rdy_exp;
  logic ov_exp;
  logic filled_exp;

  task automatic model_clear();
    for (int i = 0; i < D; i++) win[i] = 0;
    mptr = 0; msum = 0; mfill = 0; clr_left = D; last_out = 0;
  endtask

  // Drive one cycle, record ready before the edge, update the model at the edge.
  task automatic drive(input stim_t s);
    enable = s.en; flush = s.fl; in_valid = s.v; in_distance = W'(s.d);
    #1;
    rdy_exp = s.en && (clr_left == 0) && !s.fl;
    rdy_obs = in_ready;
    @(posedge clk);
    ov_exp = 1'b0;
    if (s.en) begin
      if (s.fl) begin
        model_clear();
      end else if (clr_left > 0) begin
        clr_left--;
      end else if (s.v) begin
        msum = msum + s.d - win[mptr];
        win[mptr] = s.d;
        mptr = (mptr + 1) % D;
        if (mfill < D) mfill++;
        last_out = msum / D;
        exp_q.push_back(last_out);
        ov_exp = 1'b1;
      end
    end
    filled_exp = (mfill == D);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b0; flush = 1'b0; in_valid = 1'b0; in_distance = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    enable = 1'b1; in_valid = 1'b1;
    #1;
    n_cmp++; if (out_distance !== '0) begin n_bad++; $display("FAIL reset out_distance: got %0d want 0", out_distance); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (filled !== 1'b0) begin n_bad++; $display("FAIL reset filled: got %b want 0", filled); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_clear_ramp();
    stim_t s;
    for (int i = 0; i < D; i++) begin
      s = '{1'b1, 1'b0, 1'b1, 7};
      drive(s);
      n_cmp++; if (rdy_obs !== 1'b0) begin n_bad++; $display("FAIL clear in_ready cyc %0d: got %b want 0", i, rdy_obs); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clear out_valid cyc %0d: got %b want 0", i, out_valid); end
      n_cmp++; if (out_distance !== '0) begin n_bad++; $display("FAIL clear out_distance cyc %0d: got %0d want 0", i, out_distance); end
      n_cmp++; if (filled !== 1'b0) begin n_bad++; $display("FAIL clear filled cyc %0d: got %b want 0", i, filled); end
    end
    enable = 1'b1; flush = 1'b0; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clear ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_average_wrap();
    stim_t rows[$];
    int e;
    rows = '{'{1,0,1,100}, '{1,0,1,200}, '{1,0,1,300}, '{1,0,1,400}, '{1,0,1,800},
             '{1,0,0,0},
             '{1,0,1,8191}, '{1,0,1,8191}, '{1,0,1,8191}, '{1,0,1,8191}};
    foreach (rows[i]) begin
      drive(rows[i]);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL avg in_ready row %0d: got %b want %b", i, rdy_obs, rdy_exp); end
      n_cmp++; if (out_valid !== ov_exp) begin n_bad++; $display("FAIL avg out_valid row %0d: got %b want %b", i, out_valid, ov_exp); end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL avg scoreboard row %0d: got %0d want none", i, out_distance); end
        else begin e = exp_q.pop_front(); if (out_distance !== W'(e)) begin n_bad++; $display("FAIL avg result row %0d: got %0d want %0d", i, out_distance, e); end end
      end
      n_cmp++; if (out_distance !== W'(last_out)) begin n_bad++; $display("FAIL avg hold row %0d: got %0d want %0d", i, out_distance, last_out); end
      n_cmp++; if (filled !== filled_exp) begin n_bad++; $display("FAIL avg filled row %0d: got %b want %b", i, filled, filled_exp); end
    end
    n_cmp++; if (out_distance !== W'(8191)) begin n_bad++; $display("FAIL avg saturate: got %0d want 8191", out_distance); end
  endtask

  task automatic test_truncation();
    stim_t rows[$];
    int e;
    rows = '{'{1,1,0,0}, '{1,0,0,0}, '{1,0,0,0}, '{1,0,0,0}, '{1,0,0,0},
             '{1,0,1,1}, '{1,0,1,1}, '{1,0,1,1}, '{1,0,1,2}};
    foreach (rows[i]) begin
      drive(rows[i]);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL trunc in_ready row %0d: got %b want %b", i, rdy_obs, rdy_exp); end
      n_cmp++; if (out_valid !== ov_exp) begin n_bad++; $display("FAIL trunc out_valid row %0d: got %b want %b", i, out_valid, ov_exp); end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL trunc scoreboard row %0d: got %0d want none", i, out_distance); end
        else begin e = exp_q.pop_front(); if (out_distance !== W'(e)) begin n_bad++; $display("FAIL trunc result row %0d: got %0d want %0d", i, out_distance, e); end end
      end
      n_cmp++; if (out_distance !== W'(last_out)) begin n_bad++; $display("FAIL trunc hold row %0d: got %0d want %0d", i, out_distance, last_out); end
      n_cmp++; if (filled !== filled_exp) begin n_bad++; $display("FAIL trunc filled row %0d: got %b want %b", i, filled, filled_exp); end
    end
    n_cmp++; if (out_distance !== W'(1)) begin n_bad++; $display("FAIL trunc final: got %0d want 1", out_distance); end
  endtask

  task automatic test_flush();
    stim_t rows[$];
    int e;
    rows = '{'{1,0,1,10}, '{1,0,1,20}, '{1,0,1,30},
             '{1,1,1,99},
             '{1,0,1,55}, '{1,0,1,55}, '{1,0,1,55}, '{1,0,1,55},
             '{1,0,1,40}, '{1,0,0,0}};
    foreach (rows[i]) begin
      drive(rows[i]);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL flush in_ready row %0d: got %b want %b", i, rdy_obs, rdy_exp); end
      n_cmp++; if (out_valid !== ov_exp) begin n_bad++; $display("FAIL flush out_valid row %0d: got %b want %b", i, out_valid, ov_exp); end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL flush scoreboard row %0d: got %0d want none", i, out_distance); end
        else begin e = exp_q.pop_front(); if (out_distance !== W'(e)) begin n_bad++; $display("FAIL flush result row %0d: got %0d want %0d", i, out_distance, e); end end
      end
      n_cmp++; if (out_distance !== W'(last_out)) begin n_bad++; $display("FAIL flush hold row %0d: got %0d want %0d", i, out_distance, last_out); end
      n_cmp++; if (filled !== filled_exp) begin n_bad++; $display("FAIL flush filled row %0d: got %b want %b", i, filled, filled_exp); end
    end
    n_cmp++; if (out_distance !== W'(10)) begin n_bad++; $display("FAIL flush first_after: got %0d want 10", out_distance); end
  endtask

  task automatic test_enable_pause();
    stim_t rows[$];
    int e;
    rows = '{'{1,1,0,0},
             '{1,0,1,5}, '{1,0,1,5}, '{0,0,1,5}, '{0,0,1,5}, '{1,0,1,5}, '{1,0,1,5},
             '{1,0,1,100}, '{0,0,1,200}, '{0,0,1,200}, '{1,0,1,200}, '{1,0,1,300},
             '{1,0,1,400}, '{0,0,1,900}, '{1,0,0,0}};
    foreach (rows[i]) begin
      drive(rows[i]);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL enable in_ready row %0d: got %b want %b", i, rdy_obs, rdy_exp); end
      n_cmp++; if (out_valid !== ov_exp) begin n_bad++; $display("FAIL enable out_valid row %0d: got %b want %b", i, out_valid, ov_exp); end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL enable scoreboard row %0d: got %0d want none", i, out_distance); end
        else begin e = exp_q.pop_front(); if (out_distance !== W'(e)) begin n_bad++; $display("FAIL enable result row %0d: got %0d want %0d", i, out_distance, e); end end
      end
      n_cmp++; if (out_distance !== W'(last_out)) begin n_bad++; $display("FAIL enable hold row %0d: got %0d want %0d", i, out_distance, last_out); end
      n_cmp++; if (filled !== filled_exp) begin n_bad++; $display("FAIL enable filled row %0d: got %b want %b", i, filled, filled_exp); end
    end
    n_cmp++; if (filled !== 1'b1) begin n_bad++; $display("FAIL enable filled_final: got %b want 1", filled); end
  endtask

  initial begin
    test_reset();
    test_clear_ramp();
    test_average_wrap();
    test_truncation();
    test_flush();
    test_enable_pause();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_distance_averager
